spi_lcd_tx: RTL and testbench

SPI_LCD_TX -- requirements
Module: spi_lcd_tx

---
 rtl/lcd_pkg.sv | 17 +
 rtl/sck_tick.sv | 29 ++
 rtl/spi_lcd_tx.sv | 145 ++++++++++++++
 tb/tb_spi_lcd_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state type and constants for the ILI9341 SPI transmitter
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCK_LO,
    SCK_HI,
    CS_HOLD
  } lcd_state_t;

  localparam logic LCD_CMD  = 1'b0;
  localparam logic LCD_DATA = 1'b1;

  localparam int DEFAULT_FRECUENCY_IN  = 125000000;
  localparam int DEFAULT_FRECUENCY_SCK = 10000000;

endpackage

// File: rtl/sck_tick.sv
// rtl/sck_tick.sv - one-cycle enable every HALF system clocks, restartable
module sck_tick #(
  parameter int HALF = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(HALF + 1);
  localparam logic [CW-1:0] TERM = CW'(HALF - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (en) begin
      count <= (count == TERM) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == TERM);

endmodule

// File: rtl/spi_lcd_tx.sv
// rtl/spi_lcd_tx.sv - byte-wide SPI mode-0 transmitter for the ILI9341 with D/C and chip-select framing
module spi_lcd_tx
  import lcd_pkg::*;
#(
  parameter int FRECUENCY_IN  = DEFAULT_FRECUENCY_IN,
  parameter int FRECUENCY_SCK = DEFAULT_FRECUENCY_SCK
) (
  input  logic       i_clk_FPGA,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  input  logic       i_dc,
  input  logic       i_last,
  output logic       o_sck,
  output logic       o_mosi,
  output logic       o_cs_n,
  output logic       o_dc,
  output logic       o_done
);

  localparam int HALF = (FRECUENCY_IN / FRECUENCY_SCK) / 2;

  if (HALF < 1) begin : g_half_check
    $fatal(1, "spi_lcd_tx: FRECUENCY_IN/FRECUENCY_SCK too small, HALF must be >= 1");
  end

  lcd_state_t state, state_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] shift, shift_next;
  logic       last_q, last_next;
  logic       cs_released, cs_released_next;
  logic       sck_next, mosi_next, cs_n_next, dc_next, done_next;
  logic       accept, tick;

  assign o_ready = (state == IDLE);
  assign accept  = i_valid && o_ready;

  sck_tick #(.HALF(HALF)) u_sck_tick (
    .clk     (i_clk_FPGA),
    .rst_n   (i_rst_n),
    .en      (state != IDLE),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge i_clk_FPGA or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      last_q      <= 1'b0;
      cs_released <= 1'b0;
      o_sck       <= 1'b0;
      o_mosi      <= 1'b0;
      o_cs_n      <= 1'b1;
      o_dc        <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      shift       <= shift_next;
      last_q      <= last_next;
      cs_released <= cs_released_next;
      o_sck       <= sck_next;
      o_mosi      <= mosi_next;
      o_cs_n      <= cs_n_next;
      o_dc        <= dc_next;
      o_done      <= done_next;
    end
  end

  always_comb begin
    state_next       = state;
    bit_cnt_next     = bit_cnt;
    shift_next       = shift;
    last_next        = last_q;
    cs_released_next = cs_released;
    sck_next         = o_sck;
    mosi_next        = o_mosi;
    cs_n_next        = o_cs_n;
    dc_next          = o_dc;
    done_next        = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_next   = SCK_LO;
          bit_cnt_next = '0;
          shift_next   = {i_data[6:0], 1'b0};
          mosi_next    = i_data[7];
          dc_next      = i_dc;
          last_next    = i_last;
          cs_n_next    = 1'b0;
          sck_next     = 1'b0;
        end
      end

      SCK_LO: begin
        if (tick) begin
          state_next = SCK_HI;
          sck_next   = 1'b1;
        end
      end

      SCK_HI: begin
        if (tick) begin
          sck_next = 1'b0;
          if (bit_cnt == 3'd7) begin
            // MOSI keeps bit 0; CS stays low so a following byte can chain without a gap
            done_next    = 1'b1;
            bit_cnt_next = '0;
            if (last_q) begin
              state_next       = CS_HOLD;
              cs_released_next = 1'b0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            state_next   = SCK_LO;
            bit_cnt_next = bit_cnt + 3'd1;
            mosi_next    = shift[7];
            shift_next   = {shift[6:0], 1'b0};
          end
        end
      end

      CS_HOLD: begin
        // first tick releases CS, second tick guarantees the CS-high time before re-arming
        if (tick) begin
          if (!cs_released) begin
            cs_n_next        = 1'b1;
            cs_released_next = 1'b1;
          end else begin
            state_next       = IDLE;
            cs_released_next = 1'b0;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_lcd_tx.sv
// tb/tb_spi_lcd_tx.sv - directed scoreboard bench for spi_lcd_tx at HALF=6 and HALF=1
module tb_spi_lcd_tx;
  import lcd_pkg::*;

  localparam int HALF0 = (125000000 / 10000000) / 2;
  localparam int HALF1 = (125000000 / 62500000) / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n = 2'b00;
  logic [1:0] valid = 2'b00;
  logic [1:0] dcv   = 2'b00;
  logic [1:0] lastv = 2'b00;
  logic [7:0] data [2];
  logic [1:0] rdy_w, sck_w, mosi_w, cs_w, dco_w, done_w;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  logic [8:0] exp_b;
  int nbits [2];
  int last_rise [2];
  int rises [2];
  int cs_hi_cnt [2];
  int done_cnt [2];
  int acc_cnt [2];
  logic [7:0] rx [2];
  logic [1:0] sck_p = 2'b00;

  spi_lcd_tx dut0 (
    .i_clk_FPGA (clk),       .i_rst_n (rst_n[0]), .i_valid (valid[0]), .o_ready (rdy_w[0]),
    .i_data     (data[0]),   .i_dc    (dcv[0]),   .i_last  (lastv[0]), .o_sck   (sck_w[0]),
    .o_mosi     (mosi_w[0]), .o_cs_n  (cs_w[0]),  .o_dc    (dco_w[0]), .o_done  (done_w[0])
  );

  spi_lcd_tx #(.FRECUENCY_SCK(62500000)) dut1 (
    .i_clk_FPGA (clk),       .i_rst_n (rst_n[1]), .i_valid (valid[1]), .o_ready (rdy_w[1]),
    .i_data     (data[1]),   .i_dc    (dcv[1]),   .i_last  (lastv[1]), .o_sck   (sck_w[1]),
    .o_mosi     (mosi_w[1]), .o_cs_n  (cs_w[1]),  .o_dc    (dco_w[1]), .o_done  (done_w[1])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++)
      if (valid[k] && rdy_w[k]) acc_cnt[k]++;
  end

  // bit-level monitor: rebuild each byte from MOSI at SCK rising edges and score it
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        nbits[k] = 0;
        sck_p[k] = 1'b0;
      end else begin
        if (cs_w[k]) cs_hi_cnt[k]++;
        if (done_w[k]) done_cnt[k]++;
        if (sck_w[k] && !sck_p[k]) begin
          rises[k]++;
          chk("cs_low_at_sck", cs_w[k], 0);
          if (nbits[k] > 0) chk("sck_period", cyc - last_rise[k], (k == 0) ? 2 * HALF0 : 2 * HALF1);
          last_rise[k] = cyc;
          rx[k] = {rx[k][6:0], mosi_w[k]};
          nbits[k]++;
          if (nbits[k] == 8) begin
            nbits[k] = 0;
            if (k == 0) begin
              chk("sb0_nonempty", q0.size() > 0, 1);
              if (q0.size() > 0) begin
                exp_b = q0.pop_front();
                chk("sb0_byte", {dco_w[0], rx[0]}, exp_b);
              end
            end else begin
              chk("sb1_nonempty", q1.size() > 0, 1);
              if (q1.size() > 0) begin
                exp_b = q1.pop_front();
                chk("sb1_byte", {dco_w[1], rx[1]}, exp_b);
              end
            end
          end
        end
        sck_p[k] = sck_w[k];
      end
    end
  end

  task automatic send(input int k, input logic [7:0] d, input logic dc, input logic last, output int acc);
    logic ok = 1'b0;
    valid[k] = 1'b1;
    data[k]  = d;
    dcv[k]   = dc;
    lastv[k] = last;
    for (int n = 0; n < 3000; n++) begin
      if (rdy_w[k]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_bound", ok, 1);
    acc = cyc + 1;
    if (k == 0) q0.push_back({dc, d});
    else q1.push_back({dc, d});
  endtask

  task automatic wait_sig(input string tag, input int k, input int which, input logic val, output int at);
    logic hit = 1'b0;
    logic s;
    at = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      s = (which == 0) ? done_w[k] : (which == 1) ? cs_w[k] : rdy_w[k];
      if (s === val) begin
        hit = 1'b1;
        at = cyc;
        break;
      end
    end
    chk(tag, hit, 1);
  endtask

  initial begin
    int a1, a2, t, t2, base, rel;
    data[0] = '0;
    data[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_sck", sck_w[0], 0);
    chk("rst_mosi", mosi_w[0], 0);
    chk("rst_cs_n", cs_w[0], 1);
    chk("rst_dc", dco_w[0], 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_ready", rdy_w[0], 1);

    rst_n = 2'b11;
    rel = cyc;
    send(0, 8'h2A, LCD_CMD, 1'b1, a1);
    chk("first_accept", a1 - rel, 1);
    @(negedge clk);
    valid[0] = 1'b0;
    wait_sig("wait_done_2a", 0, 0, 1'b1, t);
    chk("done_time", t - a1, 16 * HALF0);
    chk("cs_low_at_done", cs_w[0], 0);
    chk("dc_cmd", dco_w[0], LCD_CMD);
    @(negedge clk);
    chk("done_width", done_w[0], 0);
    wait_sig("wait_cs_2a", 0, 1, 1'b1, t);
    chk("cs_release_time", t - a1, 17 * HALF0);
    chk("not_ready_in_hold", rdy_w[0], 0);
    wait_sig("wait_ready_2a", 0, 2, 1'b1, t2);
    chk("cs_high_gap", (t2 - t) >= HALF0, 1);
    chk("rises_first", rises[0], 8);

    base = rises[0];
    send(0, 8'hA5, LCD_DATA, 1'b0, a1);
    @(negedge clk);
    data[0]  = 8'h3C;
    lastv[0] = 1'b1;
    rel = cs_hi_cnt[0];
    send(0, 8'h3C, LCD_DATA, 1'b1, a2);
    chk("b2b_accept", a2 - a1, 16 * HALF0 + 1);
    chk("b2b_done_with_ready", done_w[0], 1);
    @(negedge clk);
    valid[0] = 1'b0;
    wait_sig("wait_done_3c", 0, 0, 1'b1, t);
    chk("b2b_done2", t - a2, 16 * HALF0);
    chk("b2b_cs_held", cs_hi_cnt[0] - rel, 0);
    chk("b2b_rises", rises[0] - base, 16);
    wait_sig("wait_ready_3c", 0, 2, 1'b1, t);

    t = acc_cnt[0];
    send(0, 8'h5A, LCD_DATA, 1'b1, a1);
    while (cyc < a1 + 100) begin
      @(negedge clk);
      data[0] = 8'($urandom);
    end
    chk("single_accept", acc_cnt[0] - t, 1);
    valid[0] = 1'b0;
    wait_sig("wait_ready_5a", 0, 2, 1'b1, t);

    t = done_cnt[0];
    send(0, 8'h81, LCD_CMD, 1'b1, a1);
    @(negedge clk);
    valid[0] = 1'b0;
    while (cyc < a1 + 40) @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    chk("midrst_cs_n", cs_w[0], 1);
    chk("midrst_sck", sck_w[0], 0);
    chk("midrst_mosi", mosi_w[0], 0);
    chk("midrst_done", done_w[0], 0);
    void'(q0.pop_back());
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", rdy_w[0], 1);
    chk("midrst_no_done", done_cnt[0] - t, 0);
    chk("sb0_drained", q0.size(), 0);

    send(1, 8'hFF, LCD_CMD, 1'b1, a1);
    @(negedge clk);
    valid[1] = 1'b0;
    wait_sig("wait_done_h1", 1, 0, 1'b1, t);
    chk("h1_done_time", t - a1, 16 * HALF1);
    wait_sig("wait_cs_h1", 1, 1, 1'b1, t);
    chk("h1_cs_time", t - a1, 17 * HALF1);
    wait_sig("wait_ready_h1", 1, 2, 1'b1, t2);
    chk("h1_cs_high_gap", (t2 - t) >= HALF1, 1);
    chk("h1_rises", rises[1], 8);
    chk("sb1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
